// File: rtl/imul_result_accumulator.sv
// ---------------------------------------------------------------------------
// imul_result_accumulator
//
// Sums each group of p_nterms consecutive products from the iterative integer
// multiplier modulo 2^p_nbits and emits one result per group. The result
// carries a sticky unsigned-overflow flag that is set if any addition in the
// group carried out of the top bit.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   istream_val  product valid (from the multiplier's ostream_val)
//   istream_rdy  block can accept a product this cycle
//   istream_msg  product value, treated as unsigned
//   ostream_val  group sum valid
//   ostream_rdy  downstream can accept the sum
//   ostream_msg  {overflow flag, group sum}
// ---------------------------------------------------------------------------
module imul_result_accumulator #(
   parameter int unsigned p_nterms = 4,   // products per group, 1..256
   parameter int unsigned p_nbits  = 32   // product and sum width
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               istream_val,
   output logic               istream_rdy,
   input  logic [p_nbits-1:0] istream_msg,
   output logic               ostream_val,
   input  logic               ostream_rdy,
   output logic [p_nbits:0]   ostream_msg
);

   typedef enum logic {
      ACC  = 1'b0,   // collecting products of the current group
      DONE = 1'b1    // group sum waiting to be taken downstream
   } state_e;

   // Index of the final product in a group.
   localparam logic [8:0] LAST = 9'(p_nterms - 1);

   state_e             state_q, state_d;
   logic [p_nbits-1:0] acc_q,   acc_d;
   logic [8:0]         count_q, count_d;
   logic               ovf_q,   ovf_d;

   logic [p_nbits:0]   sum;
   logic               in_xfer;
   logic               out_xfer;

   // One extra bit so the carry-out is visible for the overflow flag.
   assign sum      = {1'b0, acc_q} + {1'b0, istream_msg};
   assign in_xfer  = istream_val && istream_rdy;
   assign out_xfer = ostream_val && ostream_rdy;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (reset) begin
         state_q <= ACC;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: hold-by-default assignments up front keep this block free of
      // inferred latches on paths that do not touch a given signal.
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      case (state_q)
         ACC: begin
            if (in_xfer) begin
               acc_d = sum[p_nbits-1:0];
               ovf_d = ovf_q | sum[p_nbits];
               if (count_q == LAST) begin
                  state_d = DONE;
                  count_d = '0;
               end else begin
                  count_d = count_q + 9'd1;
               end
            end
         end

         DONE: begin
            if (out_xfer) begin
               ovf_d = 1'b0;
               if (in_xfer) begin
                  // The product arriving as the sum leaves opens the next
                  // group; with single-product groups it is already complete.
                  acc_d = istream_msg;
                  if (p_nterms == 1) begin
                     state_d = DONE;
                     count_d = '0;
                  end else begin
                     state_d = ACC;
                     count_d = 9'd1;
                  end
               end else begin
                  acc_d   = '0;
                  count_d = '0;
                  state_d = ACC;
               end
            end
         end

         default: state_d = ACC;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   always_comb begin
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      if (!reset) begin
         case (state_q)
            ACC:  istream_rdy = 1'b1;
            DONE: begin
               ostream_val = 1'b1;
               // Only take a new product in the cycle the sum leaves, so the
               // multiplier is never stalled longer than the downstream is.
               istream_rdy = ostream_rdy;
            end
            default: begin
               istream_rdy = 1'b0;
               ostream_val = 1'b0;
            end
         endcase
      end
   end

   assign ostream_msg = {ovf_q, acc_q};

endmodule

// File: tb/tb_imul_result_accumulator.sv
// ---------------------------------------------------------------------------
// tb_imul_result_accumulator
//
// Directed bench for imul_result_accumulator. Two instances share clock and
// reset: one with four products per group, one with single-product groups.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_imul_result_accumulator;

   logic        clk;
   logic        reset;

   // Four-product instance.
   logic        a_ival, a_irdy, a_oval, a_ordy;
   logic [31:0] a_imsg;
   logic [32:0] a_omsg;

   // Single-product instance.
   logic        b_ival, b_irdy, b_oval, b_ordy;
   logic [31:0] b_imsg;
   logic [32:0] b_omsg;

   int vectors;
   int miscompares;

   imul_result_accumulator #(.p_nterms(4), .p_nbits(32)) dut4 (
      .clk         (clk),
      .reset       (reset),
      .istream_val (a_ival),
      .istream_rdy (a_irdy),
      .istream_msg (a_imsg),
      .ostream_val (a_oval),
      .ostream_rdy (a_ordy),
      .ostream_msg (a_omsg)
   );

   imul_result_accumulator #(.p_nterms(1), .p_nbits(32)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .istream_val (b_ival),
      .istream_rdy (b_irdy),
      .istream_msg (b_imsg),
      .ostream_val (b_oval),
      .ostream_rdy (b_ordy),
      .ostream_msg (b_omsg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   task automatic test_reset();
      reset  = 1'b1;
      a_ival = 1'b0; a_imsg = '0; a_ordy = 1'b1;
      b_ival = 1'b0; b_imsg = '0; b_ordy = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         vectors++;
         if (a_oval !== 1'b0 || a_irdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a: got val=%b rdy=%b required val=0 rdy=0", a_oval, a_irdy);
         end
         vectors++;
         if (b_oval !== 1'b0 || b_irdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b: got val=%b rdy=%b required val=0 rdy=0", b_oval, b_irdy);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (a_oval !== 1'b0 || a_irdy !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_a: got val=%b rdy=%b required val=0 rdy=1", a_oval, a_irdy);
      end
      vectors++;
      if (b_oval !== 1'b0 || b_irdy !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_b: got val=%b rdy=%b required val=0 rdy=1", b_oval, b_irdy);
      end
   endtask

   // ------------------------------------------------------------------------
   // 3+5+7+9 back-to-back with the sink always ready.
   task automatic test_basic_group();
      logic [31:0] prod [4];
      prod = '{32'd3, 32'd5, 32'd7, 32'd9};
      a_ordy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_ival = 1'b1; a_imsg = prod[i];
         #1;
         vectors++;
         if (a_irdy !== 1'b1 || a_oval !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_in%0d: got rdy=%b val=%b required rdy=1 val=0", i, a_irdy, a_oval);
         end
      end
      @(negedge clk);
      a_ival = 1'b0;
      #1;
      vectors++;
      if (a_oval !== 1'b1 || a_omsg !== {1'b0, 32'h0000_0018}) begin
         miscompares++;
         $display("FAIL basic_out: got val=%b msg=%h required val=1 msg=%h",
                  a_oval, a_omsg, {1'b0, 32'h0000_0018});
      end
      @(negedge clk); #1;
      vectors++;
      if (a_oval !== 1'b0 || a_irdy !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_after: got val=%b rdy=%b required val=0 rdy=1", a_oval, a_irdy);
      end
   endtask

   // ------------------------------------------------------------------------
   // Wrap past 2^32 sets the flag; the following group starts clean.
   task automatic test_overflow();
      logic [31:0] prod [8];
      prod = '{32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h1};
      a_ordy = 1'b1;
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_ival = 1'b1; a_imsg = prod[g*4 + i];
         end
         @(negedge clk);
         a_ival = 1'b0;
         #1;
         vectors++;
         if (g == 0 && (a_oval !== 1'b1 || a_omsg !== {1'b1, 32'h0000_0001})) begin
            miscompares++;
            $display("FAIL ovf_wrap: got val=%b msg=%h required val=1 msg=%h",
                     a_oval, a_omsg, {1'b1, 32'h0000_0001});
         end
         if (g == 1 && (a_oval !== 1'b1 || a_omsg !== {1'b0, 32'h0000_0004})) begin
            miscompares++;
            $display("FAIL ovf_cleared: got val=%b msg=%h required val=1 msg=%h",
                     a_oval, a_omsg, {1'b0, 32'h0000_0004});
         end
      end
   endtask

   // ------------------------------------------------------------------------
   // Sink stalls for 5 cycles with a product waiting; on release the sum
   // leaves and the waiting product opens the next group as its first term.
   task automatic test_back_pressure();
      logic [31:0] prod [4];
      prod = '{32'd1, 32'd2, 32'd3, 32'd4};
      a_ordy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_ival = 1'b1; a_imsg = prod[i];
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         a_ordy = 1'b0; a_ival = 1'b1; a_imsg = 32'd50;
         #1;
         vectors++;
         if (a_irdy !== 1'b0 || a_oval !== 1'b1 || a_omsg !== {1'b0, 32'd10}) begin
            miscompares++;
            $display("FAIL bp_stall%0d: got rdy=%b val=%b msg=%h required rdy=0 val=1 msg=%h",
                     c, a_irdy, a_oval, a_omsg, {1'b0, 32'd10});
         end
      end
      @(negedge clk);
      a_ordy = 1'b1;
      #1;
      vectors++;
      if (a_irdy !== 1'b1 || a_oval !== 1'b1 || a_omsg !== {1'b0, 32'd10}) begin
         miscompares++;
         $display("FAIL bp_release: got rdy=%b val=%b msg=%h required rdy=1 val=1 msg=%h",
                  a_irdy, a_oval, a_omsg, {1'b0, 32'd10});
      end
      // Three more products complete the group started by 50: 50+60+70+80.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_imsg = 32'd60 + 32'(i * 10);
         #1;
         vectors++;
         if (a_oval !== 1'b0 || a_irdy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_next%0d: got val=%b rdy=%b required val=0 rdy=1", i, a_oval, a_irdy);
         end
      end
      @(negedge clk);
      a_ival = 1'b0;
      #1;
      vectors++;
      if (a_oval !== 1'b1 || a_omsg !== {1'b0, 32'd260}) begin
         miscompares++;
         $display("FAIL bp_second_sum: got val=%b msg=%h required val=1 msg=%h",
                  a_oval, a_omsg, {1'b0, 32'd260});
      end
   endtask

   // ------------------------------------------------------------------------
   // Single-product groups stream one result per cycle without leaving DONE.
   task automatic test_single_term();
      logic [31:0] prod [3];
      prod = '{32'd10, 32'd20, 32'd30};
      b_ordy = 1'b1;
      @(negedge clk);
      b_ival = 1'b1; b_imsg = prod[0];
      #1;
      vectors++;
      if (b_irdy !== 1'b1 || b_oval !== 1'b0) begin
         miscompares++;
         $display("FAIL single_first: got rdy=%b val=%b required rdy=1 val=0", b_irdy, b_oval);
      end
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) b_imsg = prod[i];
         else       b_ival = 1'b0;
         #1;
         vectors++;
         if (b_oval !== 1'b1 || b_irdy !== 1'b1 || b_omsg !== {1'b0, prod[i-1]}) begin
            miscompares++;
            $display("FAIL single_out%0d: got val=%b rdy=%b msg=%h required val=1 rdy=1 msg=%h",
                     i - 1, b_oval, b_irdy, b_omsg, {1'b0, prod[i-1]});
         end
      end
      @(negedge clk); #1;
      vectors++;
      if (b_oval !== 1'b0) begin
         miscompares++;
         $display("FAIL single_idle: got val=%b required val=0", b_oval);
      end
   endtask

   // ------------------------------------------------------------------------
   // Partial sum 100+200 is dropped by reset; 1+2+3+4 forms the next group.
   task automatic test_reset_mid_group();
      logic [31:0] prod [4];
      prod = '{32'd1, 32'd2, 32'd3, 32'd4};
      a_ordy = 1'b1;
      @(negedge clk); a_ival = 1'b1; a_imsg = 32'd100;
      @(negedge clk); a_imsg = 32'd200;
      @(negedge clk);
      a_ival = 1'b0; reset = 1'b1;
      #1;
      vectors++;
      if (a_oval !== 1'b0 || a_irdy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_during: got val=%b rdy=%b required val=0 rdy=0", a_oval, a_irdy);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_ival = 1'b1; a_imsg = prod[i];
         #1;
         vectors++;
         if (a_oval !== 1'b0 || a_irdy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_in%0d: got val=%b rdy=%b required val=0 rdy=1", i, a_oval, a_irdy);
         end
      end
      @(negedge clk);
      a_ival = 1'b0;
      #1;
      vectors++;
      if (a_oval !== 1'b1 || a_omsg !== {1'b0, 32'h0000_000A}) begin
         miscompares++;
         $display("FAIL midreset_sum: got val=%b msg=%h required val=1 msg=%h",
                  a_oval, a_omsg, {1'b0, 32'h0000_000A});
      end
   endtask

   // ------------------------------------------------------------------------
   // Products of (2,3),(4,5),(6,7),(8,9) arriving with random gaps and a
   // randomly stalled sink; the sum must be the plain sum of the products.
   task automatic test_random_gaps();
      int          opa [4];
      int          opb [4];
      logic [31:0] p;
      logic [31:0] expected;
      int          gaps;
      opa = '{2, 4, 6, 8};
      opb = '{3, 5, 7, 9};
      expected = '0;
      for (int i = 0; i < 4; i++) begin
         p = 32'(opa[i] * opb[i]);
         expected = expected + p;
         gaps = $urandom_range(0, 3);
         repeat (gaps) begin
            @(negedge clk);
            a_ival = 1'b0;
            a_ordy = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         a_ival = 1'b1; a_imsg = p;
         #1;
         vectors++;
         if (a_irdy !== 1'b1 || a_oval !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_in%0d: got rdy=%b val=%b required rdy=1 val=0", i, a_irdy, a_oval);
         end
      end
      gaps = $urandom_range(1, 4);
      for (int c = 0; c < gaps; c++) begin
         @(negedge clk);
         a_ival = 1'b0; a_ordy = 1'b0;
         #1;
         vectors++;
         if (a_oval !== 1'b1 || a_omsg !== {1'b0, expected}) begin
            miscompares++;
            $display("FAIL gaps_hold%0d: got val=%b msg=%h required val=1 msg=%h",
                     c, a_oval, a_omsg, {1'b0, expected});
         end
      end
      @(negedge clk);
      a_ordy = 1'b1;
      @(negedge clk); #1;
      vectors++;
      if (a_oval !== 1'b0) begin
         miscompares++;
         $display("FAIL gaps_drain: got val=%b required val=0", a_oval);
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_basic_group();
      test_overflow();
      test_back_pressure();
      test_single_term();
      test_reset_mid_group();
      test_random_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
